anim_sequencer: RTL and testbench
=================================

ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 419583, clk cycles per animation tick (60 Hz at 25.175 MHz); legal range 2..2^20.
REQ-002 Parameter FRAME_W, default 46, sprite frame width in pixels; same for all animations.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 move_req  in  movement_state  movement requested by player FSM; sampled every clk.
REQ-006 anim_tick  out  1  one-clk-wide pulse, once every TICK_DIV clks.
REQ-007 anim_state  out  movement_state  animation currently playing.
REQ-008 anim_frame  out  4  frame index within anim_state.
REQ-009 anim_row  out  11  sprite-sheet row offset for anim_state.
REQ-010 anim_col  out  11  sprite-sheet column offset, anim_frame*FRAME_W.
REQ-011 max_width  out  6  frame width, constant FRAME_W.
REQ-012 busy  out  1  high while a one-shot animation holds the lock.

Function
REQ-013 Tick divider: counter 0..TICK_DIV-1, wraps to 0; anim_tick high exactly in the clk where counter == TICK_DIV-1.
REQ-014 anim_state, anim_frame, hold counter and busy update only on the clk edge where anim_tick is high; held otherwise.
REQ-015 Per-state table (NFRAMES, HOLD ticks/frame, ROW, LOOP): IDLE 4,8,0,loop; WALK 8,4,48,loop; JUMP 3,6,96,loop; ATTACK 5,3,144,one-shot.
REQ-016 Unlocked tick, move_req != anim_state: anim_state <= move_req, anim_frame <= 0, hold <= 0; busy <= 1 iff move_req is one-shot.
REQ-017 Unlocked tick, move_req == anim_state: hold increments; at hold == HOLD-1, hold <= 0 and anim_frame advances, wrapping NFRAMES-1 -> 0.
REQ-018 Locked tick (busy=1): move_req ignored; hold/frame advance as REQ-017.
REQ-019 Locked, last frame, hold == HOLD-1: busy <= 0, anim_frame <= 0, hold <= 0; anim_state <= move_req if move_req != anim_state, else IDLE.
REQ-020 Request changes between ticks are not latched; only the value present on the tick clk counts.
REQ-021 anim_row, anim_col, max_width are combinational from anim_state/anim_frame; anim_col max 7*46 = 322 fits 11 bits.
REQ-022 move_req outside the four enumerated values is treated as IDLE.
REQ-023 Latency: request to visible anim_state change is at most TICK_DIV clks (1 clk after a tick-aligned edge).

Reset
REQ-024 reset_n low asynchronously forces: divider 0, anim_tick 0, anim_state IDLE, anim_frame 0, hold 0, busy 0; hence anim_row 0, anim_col 0, max_width FRAME_W.
REQ-025 Reset mid-ATTACK drops the lock immediately; first tick after release follows REQ-016 from IDLE.
REQ-026 Divider starts counting on the first clk after reset_n deasserts; first anim_tick at clk TICK_DIV.

Structure
REQ-027 movement_state enum (IDLE, WALK, JUMP, ATTACK) and the REQ-015 table (NFRAMES, HOLD, ROW, LOOP arrays indexed by state) live in the shared smoosh_pkg.
REQ-028 Tick divider is a sub-module anim_tick_gen (params TICK_DIV; ports clk, reset_n, anim_tick); sequencing FSM remains in anim_sequencer.

Verification (TICK_DIV=4 for all)
REQ-029 Reset release, move_req=IDLE held 40 ticks -> frame sequence 0,1,2,3,0 each held 8 ticks; anim_tick period 4 clks; row 0.
REQ-030 IDLE at frame 2, move_req=WALK on a tick -> same edge anim_state=WALK, frame 0, row 48, col 0; col steps 46,92,... every 4 ticks, wrap after frame 7 (col 322).
REQ-031 move_req=ATTACK one tick, then WALK -> busy=1, 15 ticks of ATTACK (frames 0..4 x3), WALK ignored; tick 15 after start: busy=0, anim_state=WALK, frame 0.
REQ-032 ATTACK held throughout -> on completion anim_state=IDLE, busy=0; next tick restarts ATTACK with busy=1.
REQ-033 move_req pulsed JUMP for 2 clks strictly between ticks -> no state change; anim_state stays IDLE.
REQ-034 reset_n low during ATTACK frame 3, asynchronous to clk -> outputs immediately at REQ-024 values, busy=0 without a clk edge.

Source files
------------

// File: rtl/smoosh_pkg.sv
// Shared movement/animation definitions: the movement_state enum and the
// per-state animation table (frame count, ticks per frame, sheet row, looping).
package smoosh_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        JUMP   = 2'd2,
        ATTACK = 2'd3
    } movement_state;

    localparam int NUM_STATES = 4;

    // Animation table, indexed by movement_state
    localparam logic [3:0]  NFRAMES [NUM_STATES] = '{4'd4, 4'd8, 4'd3, 4'd5};
    localparam logic [3:0]  HOLD    [NUM_STATES] = '{4'd8, 4'd4, 4'd6, 4'd3};
    localparam logic [10:0] ROW     [NUM_STATES] = '{11'd0, 11'd48, 11'd96, 11'd144};
    localparam logic        LOOP    [NUM_STATES] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Map any raw request encoding onto a legal state; unknown codes mean IDLE
    function automatic movement_state sanitize_state(input logic [1:0] raw);
        case (raw)
            2'd1:    return WALK;
            2'd2:    return JUMP;
            2'd3:    return ATTACK;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/anim_tick_gen.sv
// Animation tick divider: free-running 0..TICK_DIV-1 counter, one-clk pulse
// in the cycle where the counter sits at its terminal value.
module anim_tick_gen #(
    parameter int TICK_DIV = 419583
) (
    input  logic clk,
    input  logic reset_n,
    output logic anim_tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Divider counter, wraps after the terminal value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    // Counter resets to 0 and TICK_DIV >= 2, so the pulse is low during reset
    assign anim_tick = (count == LAST);

endmodule

// File: rtl/anim_sequencer.sv
// Sprite animation sequencer: picks the animation for the requested movement,
// steps frames on animation ticks, and locks out requests while a one-shot
// animation (ATTACK) plays to completion.
module anim_sequencer
    import smoosh_pkg::*;
#(
    parameter int TICK_DIV = 419583,
    parameter int FRAME_W  = 46
) (
    input  logic          clk,
    input  logic          reset_n,
    input  movement_state move_req,
    output logic          anim_tick,
    output movement_state anim_state,
    output logic [3:0]    anim_frame,
    output logic [10:0]   anim_row,
    output logic [10:0]   anim_col,
    output logic [5:0]    max_width,
    output logic          busy
);

    movement_state state_q, state_d;
    logic [3:0]    frame_q, frame_d;
    logic [3:0]    hold_q,  hold_d;
    logic          busy_q,  busy_d;

    movement_state req;
    logic          last_hold;
    logic          last_frame;
    logic [3:0]    adv_frame;
    logic [3:0]    adv_hold;

    anim_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .anim_tick (anim_tick)
    );

    assign req        = sanitize_state(move_req);
    assign last_hold  = (hold_q  == HOLD[state_q]    - 4'd1);
    assign last_frame = (frame_q == NFRAMES[state_q] - 4'd1);

    // Normal hold/frame advance shared by the looping and locked cases
    always_comb begin
        adv_hold  = 4'(hold_q + 4'd1);
        adv_frame = frame_q;
        if (last_hold) begin
            adv_hold  = 4'd0;
            adv_frame = last_frame ? 4'd0 : 4'(frame_q + 4'd1);
        end
    end

    // Sequencer state register; only moves on tick cycles (enforced in next-state)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            frame_q <= 4'd0;
            hold_q  <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: switch animation, advance, or finish a locked one-shot
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        if (anim_tick) begin
            if (busy_q) begin
                if (last_hold && last_frame) begin
                    // One-shot done: release lock, go to a new request or rest in IDLE
                    busy_d  = 1'b0;
                    frame_d = 4'd0;
                    hold_d  = 4'd0;
                    state_d = (req != state_q) ? req : IDLE;
                end else begin
                    frame_d = adv_frame;
                    hold_d  = adv_hold;
                end
            end else if (req != state_q) begin
                state_d = req;
                frame_d = 4'd0;
                hold_d  = 4'd0;
                busy_d  = !LOOP[req];
            end else begin
                frame_d = adv_frame;
                hold_d  = adv_hold;
            end
        end
    end

    assign anim_state = state_q;
    assign anim_frame = frame_q;
    assign busy       = busy_q;
    assign anim_row   = ROW[state_q];
    assign anim_col   = 11'({7'd0, frame_q} * 11'(FRAME_W));
    assign max_width  = 6'(FRAME_W);

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with TICK_DIV=4: reset values, tick timing,
// looping animations, ATTACK lock behaviour, inter-tick glitches, async reset.
module tb_anim_sequencer;
    import smoosh_pkg::*;

    localparam int TD = 4;
    localparam int FW = 46;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    movement_state move_req = IDLE;
    logic          anim_tick;
    movement_state anim_state;
    logic [3:0]    anim_frame;
    logic [10:0]   anim_row;
    logic [10:0]   anim_col;
    logic [5:0]    max_width;
    logic          busy;

    int total = 0;
    int bad   = 0;

    anim_sequencer #(
        .TICK_DIV (TD),
        .FRAME_W  (FW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .move_req   (move_req),
        .anim_tick  (anim_tick),
        .anim_state (anim_state),
        .anim_frame (anim_frame),
        .anim_row   (anim_row),
        .anim_col   (anim_col),
        .max_width  (max_width),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance through the next tick edge; ends 1 time unit after that edge
    task automatic tick_step();
        int found = 0;
        for (int i = 0; i < 2 * TD + 2; i++) begin
            @(negedge clk);
            if (anim_tick === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("tick_seen", found, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int fr, input int bz);
        chk({tag, "_state"}, int'(anim_state), st);
        chk({tag, "_frame"}, int'(anim_frame), fr);
        chk({tag, "_busy"},  int'(busy), bz);
    endtask

    initial begin
        // Reset values
        #12;
        chk_all("rst", 0, 0, 0);
        chk("rst_tick", int'(anim_tick), 0);
        chk("rst_row",  int'(anim_row), 0);
        chk("rst_col",  int'(anim_col), 0);
        chk("rst_maxw", int'(max_width), 46);

        // Release; first tick visible in the 4th clk, period 4
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("first_tick_hi", int'(anim_tick), 1);
        @(posedge clk);
        #1;
        chk("first_tick_lo", int'(anim_tick), 0);
        chk_all("tick1", 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("second_tick_hi", int'(anim_tick), 1);
        @(posedge clk);
        #1;

        // IDLE loop: frames 0,1,2,3,0,... each for 8 ticks; stop at frame 2
        for (int k = 3; k <= 48; k++) begin
            tick_step();
            chk("idle_frame", int'(anim_frame), (k / 8) % 4);
            chk("idle_row", int'(anim_row), 0);
        end

        // Switch to WALK from IDLE frame 2
        move_req = WALK;
        tick_step();
        chk_all("walk0", 1, 0, 0);
        chk("walk0_row", int'(anim_row), 48);
        chk("walk0_col", int'(anim_col), 0);
        for (int j = 1; j <= 36; j++) begin
            tick_step();
            chk("walk_frame", int'(anim_frame), (j / 4) % 8);
            chk("walk_col", int'(anim_col), ((j / 4) % 8) * 46);
        end

        // ATTACK one tick then WALK: lock holds for 15 ticks
        move_req = ATTACK;
        tick_step();
        chk_all("atk0", 3, 0, 1);
        chk("atk0_row", int'(anim_row), 144);
        move_req = WALK;
        for (int j = 1; j <= 14; j++) begin
            tick_step();
            chk_all("atk_lock", 3, j / 3, 1);
        end
        tick_step();
        chk_all("atk_done_walk", 1, 0, 0);

        // ATTACK held throughout: finish to IDLE, then restart
        move_req = ATTACK;
        tick_step();
        chk_all("atk2_0", 3, 0, 1);
        for (int j = 1; j <= 14; j++) tick_step();
        chk_all("atk2_last", 3, 4, 1);
        tick_step();
        chk_all("atk2_done", 0, 0, 0);
        tick_step();
        chk_all("atk2_restart", 3, 0, 1);

        // Let it finish into IDLE
        move_req = IDLE;
        for (int j = 1; j <= 15; j++) tick_step();
        chk_all("atk3_done", 0, 0, 0);

        // JUMP pulse strictly between ticks is not latched
        move_req = JUMP;
        repeat (2) @(posedge clk);
        #1;
        move_req = IDLE;
        tick_step();
        chk_all("glitch", 0, 0, 0);
        chk("glitch_row", int'(anim_row), 0);

        // Async reset during ATTACK frame 3
        move_req = ATTACK;
        tick_step();
        for (int j = 1; j <= 9; j++) tick_step();
        chk_all("atk_f3", 3, 3, 1);
        chk("atk_f3_col", int'(anim_col), 138);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0);
        chk("async_rst_col", int'(anim_col), 0);
        chk("async_rst_row", int'(anim_row), 0);
        chk("async_rst_tick", int'(anim_tick), 0);
        chk("async_rst_maxw", int'(max_width), 46);

        // After release, first tick acts from IDLE
        move_req = WALK;
        @(negedge clk);
        reset_n = 1'b1;
        tick_step();
        chk_all("post_rst_walk", 1, 0, 0);
        chk("post_rst_row", int'(anim_row), 48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
